// File: rtl/uart_rx_16x.sv
// 16x-oversampled UART receiver: start, DATA_BITS data bits LSB first, optional even parity, one stop bit.
// Optional feature: define UART_RX_PARITY_EN to receive and check an even parity bit after the data bits.
`timescale 1ns/1ps
module uart_rx_16x #(
    parameter int DATA_BITS  = 8,
    parameter int OVERSAMPLE = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 baud_tick,
    input  logic                 rx_in,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    output logic                 rx_ferror,
    output logic                 rx_perror,
    output logic                 rx_busy
);
    localparam int TW = $clog2(OVERSAMPLE);
    localparam int BW = $clog2(DATA_BITS + 1);
    localparam logic [TW-1:0] TICK_MID  = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef UART_RX_PARITY_EN
        PARITY,
`endif
        STOP,
        BRK_WAIT
    } state_t;

    state_t                 state_q;
    logic                   sync1_q;
    logic                   sync2_q;
    logic [TW-1:0]          tick_q;
    logic [BW-1:0]          bit_q;
    logic [DATA_BITS-1:0]   shreg_q;
    logic [DATA_BITS-1:0]   data_q;
    logic                   valid_q;
    logic                   ferr_q;
    logic                   rx_s;

    assign rx_s = sync2_q;

    // rx_valid is a one-cycle pulse with no ready: the consumer must take rx_data and the
    // error flags in that same cycle; rx_data then holds until the next frame completes.
    assign rx_data   = data_q;
    assign rx_valid  = valid_q;
    assign rx_ferror = ferr_q;
    assign rx_busy   = (state_q != IDLE);

`ifdef UART_RX_PARITY_EN
    logic perr_q;
    logic perr_out_q;
    assign rx_perror = perr_out_q;
`else
    assign rx_perror = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            sync1_q    <= 1'b1;
            sync2_q    <= 1'b1;
            tick_q     <= '0;
            bit_q      <= '0;
            shreg_q    <= '0;
            data_q     <= '0;
            valid_q    <= 1'b0;
            ferr_q     <= 1'b0;
`ifdef UART_RX_PARITY_EN
            perr_q     <= 1'b0;
            perr_out_q <= 1'b0;
`endif
        end else begin
            sync1_q <= rx_in;
            sync2_q <= sync1_q;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
            perr_out_q <= 1'b0;
`endif
            case (state_q)
                IDLE: begin
                    if (!rx_s) begin
                        state_q <= START;
                        tick_q  <= '0;
                    end
                end
                START: begin
                    if (baud_tick) begin
                        if (tick_q == TICK_MID) begin
                            // Line back high at mid start bit means a glitch, not a frame.
                            tick_q  <= '0;
                            bit_q   <= '0;
                            state_q <= rx_s ? IDLE : DATA;
                        end else begin
                            tick_q <= tick_q + 1'b1;
                        end
                    end
                end
                DATA: begin
                    if (baud_tick) begin
                        if (tick_q == TICK_LAST) begin
                            tick_q  <= '0;
                            shreg_q <= {rx_s, shreg_q[DATA_BITS-1:1]};
                            bit_q   <= bit_q + 1'b1;
                            if (bit_q == BIT_LAST) begin
`ifdef UART_RX_PARITY_EN
                                state_q <= PARITY;
`else
                                state_q <= STOP;
`endif
                            end
                        end else begin
                            tick_q <= tick_q + 1'b1;
                        end
                    end
                end
`ifdef UART_RX_PARITY_EN
                PARITY: begin
                    if (baud_tick) begin
                        if (tick_q == TICK_LAST) begin
                            tick_q  <= '0;
                            perr_q  <= ^{shreg_q, rx_s};
                            state_q <= STOP;
                        end else begin
                            tick_q <= tick_q + 1'b1;
                        end
                    end
                end
`endif
                STOP: begin
                    if (baud_tick) begin
                        if (tick_q == TICK_LAST) begin
                            tick_q  <= '0;
                            data_q  <= shreg_q;
                            valid_q <= 1'b1;
                            ferr_q  <= ~rx_s;
`ifdef UART_RX_PARITY_EN
                            perr_out_q <= perr_q;
`endif
                            // A low stop bit may be a break; wait for the line to recover.
                            state_q <= rx_s ? IDLE : BRK_WAIT;
                        end else begin
                            tick_q <= tick_q + 1'b1;
                        end
                    end
                end
                BRK_WAIT: begin
                    if (rx_s) begin
                        state_q <= IDLE;
                        tick_q  <= '0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    tick_q  <= '0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_uart_rx_16x.sv
// Directed bench for uart_rx_16x: table of frames plus glitch, reset-abort and back-to-back sequences.
// Compile with UART_RX_PARITY_EN defined to add the parity vectors.
`timescale 1ns/1ps
module tb_uart_rx_16x;
    localparam int DB       = 8;
    localparam int OS       = 16;
    localparam int TICK_DIV = 27;
    localparam int BIT_CLKS = OS * TICK_DIV;
    localparam int W        = DB + 2;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          baud_tick = 1'b0;
    logic          rx_in = 1'b1;
    logic [DB-1:0] rx_data;
    logic          rx_valid;
    logic          rx_ferror;
    logic          rx_perror;
    logic          rx_busy;

    int checks = 0;
    int errors = 0;
    int stray  = 0;
    int tick_cnt = 0;

    logic [W-1:0] exp_q[$];
    logic [W-1:0] got_q[$];

    typedef struct {
        logic [7:0] data;
        logic       par;
        logic       stop;
        logic       hold_low;
        logic       exp_fe;
        logic       exp_pe;
    } vec_t;
    vec_t vecs[$];

    uart_rx_16x #(.DATA_BITS(DB), .OVERSAMPLE(OS)) dut (
        .clk      (clk),
        .reset    (reset),
        .baud_tick(baud_tick),
        .rx_in    (rx_in),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .rx_ferror(rx_ferror),
        .rx_perror(rx_perror),
        .rx_busy  (rx_busy)
    );

    // clock / reset / baud tick
    always #10 clk = ~clk;

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (tick_cnt == TICK_DIV - 1) begin
                baud_tick = 1'b1;
                tick_cnt  = 0;
            end else begin
                baud_tick = 1'b0;
                tick_cnt  = tick_cnt + 1;
            end
        end
    end

    // output monitor
    always @(negedge clk) begin
        if (rx_valid) got_q.push_back({rx_data, rx_ferror, rx_perror});
        else if (rx_ferror || rx_perror) stray = stray + 1;
    end

    // driver tasks
    task automatic wait_clks(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drive_bit(input logic b);
        rx_in = b;
        wait_clks(BIT_CLKS);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic par, input logic stop);
        drive_bit(1'b0);
        for (int i = 0; i < DB; i++) drive_bit(d[i]);
`ifdef UART_RX_PARITY_EN
        drive_bit(par);
`else
        if (par) rx_in = 1'b1;
`endif
        drive_bit(stop);
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks = checks + 1;
        if (got !== exp) begin
            errors = errors + 1;
            $display("FAIL %s got=%0h expected=%0h", name, got, exp);
        end
    endtask

    // scoreboard
    task automatic compare_frames(input string name);
        check({name, "_count"}, got_q.size(), exp_q.size());
        while (exp_q.size() > 0 && got_q.size() > 0)
            check(name, got_q.pop_front(), exp_q.pop_front());
        exp_q.delete();
        got_q.delete();
    endtask

    initial begin
        // positional: data, par, stop, hold_low, exp_fe, exp_pe
        vecs.push_back('{8'h55, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0});
        vecs.push_back('{8'hA3, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0});
        vecs.push_back('{8'h0F, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0});
`ifdef UART_RX_PARITY_EN
        vecs.push_back('{8'h07, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0});
        vecs.push_back('{8'h07, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1});
`endif

        reset = 1'b0;
        rx_in = 1'b1;
        wait_clks(5);
        check("rst_data",  rx_data,   8'h00);
        check("rst_valid", rx_valid,  1'b0);
        check("rst_ferr",  rx_ferror, 1'b0);
        check("rst_perr",  rx_perror, 1'b0);
        check("rst_busy",  rx_busy,   1'b0);
        reset = 1'b1;
        wait_clks(BIT_CLKS);
        got_q.delete();

        for (int v = 0; v < vecs.size(); v++) begin
            exp_q.push_back({vecs[v].data, vecs[v].exp_fe, vecs[v].exp_pe});
            send_frame(vecs[v].data, vecs[v].par, vecs[v].stop);
            if (vecs[v].hold_low) begin
                drive_bit(1'b0);
                drive_bit(1'b0);
                check("brk_busy", rx_busy, 1'b1);
                check("brk_single_valid", got_q.size(), 1);
            end
            rx_in = 1'b1;
            wait_clks(BIT_CLKS);
            check("vec_idle_busy", rx_busy, 1'b0);
            compare_frames("vec_frame");
        end

        // start-bit glitch of 5 tick periods
        rx_in = 1'b0;
        wait_clks(5 * TICK_DIV);
        check("glitch_busy", rx_busy, 1'b1);
        rx_in = 1'b1;
        wait_clks(BIT_CLKS);
        check("glitch_idle", rx_busy, 1'b0);
        check("glitch_no_valid", got_q.size(), 0);

        // reset during data bit 4 of 0xFF
        drive_bit(1'b0);
        for (int i = 0; i < 4; i++) drive_bit(1'b1);
        rx_in = 1'b1;
        wait_clks(BIT_CLKS / 2);
        check("abort_busy_before", rx_busy, 1'b1);
        reset = 1'b0;
        wait_clks(3);
        check("abort_data",  rx_data,  8'h00);
        check("abort_valid", rx_valid, 1'b0);
        check("abort_busy",  rx_busy,  1'b0);
        reset = 1'b1;
        wait_clks(6 * BIT_CLKS);
        check("abort_no_valid", got_q.size(), 0);
        exp_q.push_back({8'h3C, 1'b0, 1'b0});
        send_frame(8'h3C, 1'b0, 1'b1);
        wait_clks(BIT_CLKS);
        compare_frames("after_reset");
        check("data_hold", rx_data, 8'h3C);

        // back-to-back frames, no idle gap
        exp_q.push_back({8'h00, 1'b0, 1'b0});
        exp_q.push_back({8'hFF, 1'b0, 1'b0});
        send_frame(8'h00, 1'b0, 1'b1);
        send_frame(8'hFF, 1'b0, 1'b1);
        wait_clks(BIT_CLKS);
        compare_frames("b2b");

        check("stray_flags", stray, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
